alarm_latch_ctrl: RTL and testbench
===================================

// Module: alarm_latch_ctrl
// PURPOSE
//   Downstream consumer of the combinational 5-input alarm decoder's Alarm output.
//   Arms and disarms the system, and debounces Alarm.
//   Latches a trip, then drives the siren and a blinking status LED until the trip
//   is acknowledged or times out. Optionally counts trips.
// PARAMETERS
//   DEBOUNCE   4   consecutive high samples of alarm_in needed to trip (>=1)
//   BLINK_HALF 8   cycles per LED half-period while TRIPPED (>=1)
//   TIMEOUT    64  max cycles in TRIPPED before auto-silence (>=1)
//   CNT_W      8   width of trip_count
// PORTS
//   clk        in  1      single system clock, rising edge
//   rst        in  1      synchronous, active-high reset
//   alarm_in   in  1      Alarm from the decoder stage (async to nothing; same clk domain)
//   arm        in  1      level: 1 = system armed, 0 = disarm
//   ack        in  1      level, sampled each cycle: operator acknowledge
//   siren      out 1      siren drive
//   led        out 1      status LED
//   state_o    out 2      0=DISARMED 1=ARMED 2=TRIPPED 3=SILENCED
//   trip_count out CNT_W  number of trips since reset (see CONFIGURATION)
// BEHAVIOUR
//   - Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
//   - All state, counters and outputs are registered; outputs change only on a clk edge.
//   - Reset: state=DISARMED, siren=0, led=0, trip_count=0. All internal counters are 0.
//   - Priority each cycle: rst > arm==0 (go DISARMED) > ack > alarm/timeout events.
//   - DISARMED: siren=0, led=0. arm==1 -> ARMED next edge. The debounce counter is held at 0.
//   - ARMED: siren=0, led=1.
//       - alarm_in==1 increments the debounce counter; alarm_in==0 clears it to 0.
//       - If alarm_in==1 and the counter == DEBOUNCE-1 -> TRIPPED on that edge.
//       - So siren rises on the edge that samples the DEBOUNCE-th consecutive high.
//       - ack has no effect in ARMED.
//   - TRIPPED: siren=1.
//       - led starts at 1 on entry and toggles every BLINK_HALF cycles.
//       - The blink counter resets on entry.
//       - ack==1 -> SILENCED next edge.
//       - The timeout counter resets on entry. After TIMEOUT cycles in TRIPPED with no ack,
//         go to SILENCED (TIMEOUT cycles in TRIPPED, then the transition edge).
//       - Further alarm_in activity is ignored.
//   - SILENCED: siren=0, led=1 steady.
//       - ack==1 and alarm_in==0 in the same cycle -> ARMED, with the debounce counter = 0.
//       - ack==1 while alarm_in==1 -> stay in SILENCED, to prevent instant re-trip.
//   - arm==0 in any state -> DISARMED next edge.
//       - This wins over a simultaneous ack or trip.
//       - A trip that coincides with disarm is not counted.
//   - Debounce, blink and timeout counters: clear on every state change. They never wrap
//     (sized ceil(log2(param))+1 bits, compared with ==).
//   - Reset mid-TRIPPED: siren drops to 0 on the reset edge. Nothing is retained except
//     that trip_count is also cleared.
// CONFIGURATION
//   ALARM_TRIP_COUNT_EN defined:
//     - trip_count increments by 1 on each ARMED->TRIPPED edge.
//     - It saturates at 2**CNT_W-1 and never wraps.
//     - It clears only on rst; disarm does not clear it.
//   ALARM_TRIP_COUNT_EN undefined:
//     - trip_count is tied to 0 and no counter logic is generated.
//     - All other behaviour is identical.
// TESTING
//   1. rst=1 for 2 cycles, then release with arm=0 -> state_o=0, siren=0, led=0, trip_count=0.
//   2. Debounce glitch: arm=1; wait 1 cycle.
//      Drive alarm_in=1 for 3 cycles, then 0 (DEBOUNCE=4) -> state_o stays 1, siren stays 0.
//   3. Trip: alarm_in=1 for 4 cycles -> siren=1 and state_o=2 on the 4th sampling edge.
//      led toggles every 8 cycles. trip_count=1 (macro on) / 0 (macro off).
//   4. Ack path: in TRIPPED, ack=1 for 1 cycle -> state_o=3, siren=0, led=1.
//      Then ack=1 with alarm_in=1 -> stays at 3.
//      Then ack=1 with alarm_in=0 -> state_o=1.
//   5. Timeout: trip, then hold ack=0 -> siren high for exactly 64 cycles, then state_o=3.
//   6. Simultaneous/corner:
//      - arm=0 and ack=1 together in TRIPPED -> state_o=0.
//      - The DEBOUNCE-th alarm sample coinciding with arm=0 -> state_o=0 and
//        trip_count unchanged.
//      - Drive 300 trips with CNT_W=8 -> trip_count=255.
//      - rst asserted mid-TRIPPED -> all outputs 0 next edge.

Source files
------------

// File: rtl/alarm_latch_ctrl_if.sv
// Signal bundle between the alarm decoder/operator side and alarm_latch_ctrl.
// master drives alarm_in/arm/ack; slave (the controller) drives the status outputs.
interface alarm_latch_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             alarm_in;
   logic             arm;
   logic             ack;
   logic             siren;
   logic             led;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] trip_count;

   modport master (
      output alarm_in, arm, ack,
      input  siren, led, state_o, trip_count
   );

   modport slave (
      input  alarm_in, arm, ack,
      output siren, led, state_o, trip_count
   );
endinterface

// File: rtl/alarm_latch_ctrl.sv
// Arm/disarm, debounce, trip latch, siren/LED drive and timeout for the alarm output.
// Define ALARM_TRIP_COUNT_EN to build the saturating trip counter; otherwise trip_count is 0.
module alarm_latch_ctrl #(
   parameter int DEBOUNCE   = 4,
   parameter int BLINK_HALF = 8,
   parameter int TIMEOUT    = 64,
   parameter int CNT_W      = 8
) (
   input  logic               clk,
   input  logic               rst,
   alarm_latch_ctrl_if.slave  bus
);
   localparam int DB_W = $clog2(DEBOUNCE) + 1;
   localparam int BL_W = $clog2(BLINK_HALF) + 1;
   localparam int TO_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      S_DISARMED = 2'd0,
      S_ARMED    = 2'd1,
      S_TRIPPED  = 2'd2,
      S_SILENCED = 2'd3
   } state_t;

   state_t            state_q, state_n;
   logic [DB_W-1:0]   db_q, db_n;
   logic [BL_W-1:0]   bl_q, bl_n;
   logic [TO_W-1:0]   to_q, to_n;
   logic              led_q, led_n;
   logic              siren_q, siren_n;
   logic              trip_ev;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_DISARMED;
         db_q    <= '0;
         bl_q    <= '0;
         to_q    <= '0;
         led_q   <= 1'b0;
         siren_q <= 1'b0;
      end else begin
         state_q <= state_n;
         db_q    <= db_n;
         bl_q    <= bl_n;
         to_q    <= to_n;
         led_q   <= led_n;
         siren_q <= siren_n;
      end
   end

   always_comb begin
      state_n = state_q;
      db_n    = db_q;
      bl_n    = bl_q;
      to_n    = to_q;
      led_n   = led_q;
      trip_ev = 1'b0;

      // Disarm outranks everything, so a coincident trip is never counted.
      if (!bus.arm) begin
         state_n = S_DISARMED;
      end else begin
         case (state_q)
            S_DISARMED: state_n = S_ARMED;
            S_ARMED: begin
               if (bus.alarm_in) begin
                  if (db_q == DB_W'(DEBOUNCE - 1)) begin
                     state_n = S_TRIPPED;
                     trip_ev = 1'b1;
                  end else begin
                     db_n = db_q + 1'b1;
                  end
               end else begin
                  db_n = '0;
               end
            end
            S_TRIPPED: begin
               if (bus.ack || (to_q == TO_W'(TIMEOUT - 1))) begin
                  state_n = S_SILENCED;
               end else begin
                  to_n = to_q + 1'b1;
               end
               if (bl_q == BL_W'(BLINK_HALF - 1)) begin
                  bl_n  = '0;
                  led_n = ~led_q;
               end else begin
                  bl_n = bl_q + 1'b1;
               end
            end
            S_SILENCED: begin
               // Holding off while alarm_in is still high avoids an instant re-trip.
               if (bus.ack && !bus.alarm_in) state_n = S_ARMED;
            end
            default: state_n = S_DISARMED;
         endcase
      end

      if (state_n != state_q) begin
         db_n  = '0;
         bl_n  = '0;
         to_n  = '0;
         led_n = (state_n != S_DISARMED);
      end
      siren_n = (state_n == S_TRIPPED);
   end

   assign bus.state_o = state_q;
   assign bus.siren   = siren_q;
   assign bus.led     = led_q;

`ifdef ALARM_TRIP_COUNT_EN
   logic [CNT_W-1:0] trip_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         trip_q <= '0;
      end else if (trip_ev && (trip_q != {CNT_W{1'b1}})) begin
         trip_q <= trip_q + 1'b1;
      end
   end

   assign bus.trip_count = trip_q;
`else
   logic unused_trip_ev;
   assign unused_trip_ev = trip_ev;
   assign bus.trip_count = '0;
`endif
endmodule

// File: tb/tb_alarm_latch_ctrl.sv
// Directed and randomized checks of alarm_latch_ctrl against a cycle-count reference model.
module tb_alarm_latch_ctrl;
   localparam int DEBOUNCE   = 4;
   localparam int BLINK_HALF = 8;
   localparam int TIMEOUT    = 64;
   localparam int CNT_W      = 8;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   alarm_latch_ctrl_if #(.CNT_W(CNT_W)) bus ();

   alarm_latch_ctrl #(
      .DEBOUNCE   (DEBOUNCE),
      .BLINK_HALF (BLINK_HALF),
      .TIMEOUT    (TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference: mode 0..3, length of the current high run, cycles since trip entry, trips.
   int m_state = 0;
   int m_run   = 0;
   int m_age   = 0;
   int m_trips = 0;

   task automatic model_step(input logic r, input logic a, input logic am, input logic k);
      if (r) begin
         m_state = 0; m_run = 0; m_age = 0; m_trips = 0;
      end else if (!am) begin
         m_state = 0; m_run = 0;
      end else begin
         case (m_state)
            0: begin m_state = 1; m_run = 0; end
            1: begin
               if (a) begin
                  if (m_run + 1 == DEBOUNCE) begin
                     m_state = 2; m_age = 0; m_run = 0;
                     if (m_trips < CNT_MAX) m_trips = m_trips + 1;
                  end else begin
                     m_run = m_run + 1;
                  end
               end else begin
                  m_run = 0;
               end
            end
            2: begin
               if (k || (m_age + 1 == TIMEOUT)) m_state = 3;
               else m_age = m_age + 1;
            end
            default: begin
               if (k && !a) begin m_state = 1; m_run = 0; end
            end
         endcase
      end
   endtask

   function automatic int exp_led();
      if (m_state == 0) return 0;
      if (m_state == 2) return ((m_age / BLINK_HALF) % 2 == 0) ? 1 : 0;
      return 1;
   endfunction

   function automatic int exp_trip();
`ifdef ALARM_TRIP_COUNT_EN
      return m_trips;
`else
      return 0;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic a, input logic am, input logic k, input string tag);
      rst          = r;
      bus.alarm_in = a;
      bus.arm      = am;
      bus.ack      = k;
      @(posedge clk);
      model_step(r, a, am, k);
      #1;
      check({tag, "/state"}, 32'(bus.state_o), 32'(m_state));
      check({tag, "/siren"}, 32'(bus.siren), (m_state == 2) ? 32'd1 : 32'd0);
      check({tag, "/led"}, 32'(bus.led), 32'(exp_led()));
      check({tag, "/trip"}, 32'(bus.trip_count), 32'(exp_trip()));
   endtask

   task automatic trip_from_armed(input string tag);
      for (int i = 0; i < DEBOUNCE; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, tag);
   endtask

   initial begin
      int hi;
      int trips_exp;
      bus.alarm_in = 1'b0;
      bus.arm      = 1'b0;
      bus.ack      = 1'b0;

      // Reset and release with arm low
      cycle(1'b1, 1'b0, 1'b0, 1'b0, "rst");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, "rst");
      cycle(1'b0, 1'b0, 1'b0, 1'b0, "idle");
      check("reset_state", 32'(bus.state_o), 32'd0);
      check("reset_led", 32'(bus.led), 32'd0);
      check("reset_trip", 32'(bus.trip_count), 32'd0);

      // Debounce glitch: three highs then low must not trip
      cycle(1'b0, 1'b0, 1'b1, 1'b0, "arm");
      check("armed_led", 32'(bus.led), 32'd1);
      for (int i = 0; i < DEBOUNCE - 1; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, "glitch");
      cycle(1'b0, 1'b0, 1'b1, 1'b0, "glitch_end");
      check("glitch_state", 32'(bus.state_o), 32'd1);
      check("glitch_siren", 32'(bus.siren), 32'd0);

      // Trip on the 4th sampled high, then blink
      for (int i = 0; i < DEBOUNCE - 1; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, "pretrip");
      check("pretrip_siren", 32'(bus.siren), 32'd0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, "trip");
      check("trip_state", 32'(bus.state_o), 32'd2);
      check("trip_siren", 32'(bus.siren), 32'd1);
      check("trip_led_entry", 32'(bus.led), 32'd1);
`ifdef ALARM_TRIP_COUNT_EN
      check("trip_count1", 32'(bus.trip_count), 32'd1);
`else
      check("trip_count1", 32'(bus.trip_count), 32'd0);
`endif
      for (int i = 0; i < BLINK_HALF - 1; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, "blink");
      check("blink_last_hi", 32'(bus.led), 32'd1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, "blink");
      check("blink_first_lo", 32'(bus.led), 32'd0);

      // Acknowledge path
      cycle(1'b0, 1'b0, 1'b1, 1'b1, "ack");
      check("ack_state", 32'(bus.state_o), 32'd3);
      check("ack_led", 32'(bus.led), 32'd1);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, "ack_hold");
      check("ack_hold_state", 32'(bus.state_o), 32'd3);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, "rearm");
      check("rearm_state", 32'(bus.state_o), 32'd1);

      // Timeout: siren high for exactly TIMEOUT cycles
      trip_from_armed("to_trip");
      hi = (bus.siren === 1'b1) ? 1 : 0;
      for (int i = 0; i < 3 * TIMEOUT && bus.siren === 1'b1; i++) begin
         cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, "to_wait");
         if (bus.siren === 1'b1) hi++;
      end
      check("timeout_len", 32'(hi), 32'(TIMEOUT));
      check("timeout_state", 32'(bus.state_o), 32'd3);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, "to_rearm");

      // Disarm beats ack in TRIPPED
      trip_from_armed("c1_trip");
      cycle(1'b0, 1'b0, 1'b0, 1'b1, "disarm_ack");
      check("disarm_ack_state", 32'(bus.state_o), 32'd0);

      // Trip sample coinciding with disarm is not counted
      trips_exp = exp_trip();
      cycle(1'b0, 1'b0, 1'b1, 1'b0, "c2_arm");
      for (int i = 0; i < DEBOUNCE - 1; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, "c2_pre");
      cycle(1'b0, 1'b1, 1'b0, 1'b0, "c2_disarm");
      check("c2_state", 32'(bus.state_o), 32'd0);
      check("c2_trip", 32'(bus.trip_count), 32'(trips_exp));

      // 300 trips saturate the counter
      cycle(1'b0, 1'b0, 1'b1, 1'b0, "sat_arm");
      for (int t = 0; t < 300; t++) begin
         trip_from_armed("sat_trip");
         cycle(1'b0, 1'b0, 1'b1, 1'b1, "sat_ack");
         cycle(1'b0, 1'b0, 1'b1, 1'b1, "sat_rearm");
      end
`ifdef ALARM_TRIP_COUNT_EN
      check("sat_count", 32'(bus.trip_count), 32'd255);
`else
      check("sat_count", 32'(bus.trip_count), 32'd0);
`endif

      // Reset in the middle of TRIPPED
      trip_from_armed("rst_trip");
      cycle(1'b0, 1'b1, 1'b1, 1'b0, "rst_trip_hold");
      cycle(1'b1, 1'b1, 1'b1, 1'b1, "rst_mid");
      check("rst_mid_state", 32'(bus.state_o), 32'd0);
      check("rst_mid_siren", 32'(bus.siren), 32'd0);
      check("rst_mid_led", 32'(bus.led), 32'd0);
      check("rst_mid_trip", 32'(bus.trip_count), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         cycle(1'($urandom_range(0, 399) == 0),
               1'($urandom_range(0, 9) < 7),
               1'($urandom_range(0, 24) != 0),
               1'($urandom_range(0, 11) == 0),
               "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
